nx1_dpram_arb: RTL and testbench

//  Three-requester arbiter/sequencer for port A of the 1Kx16 dual-port RAM (nx1_dpram1k16).

---
 rtl/nx1_dpram_arb_pkg.sv | 13 +
 rtl/nx1_dpram_arb_if.sv | 13 +
 rtl/nx1_dpram_arb_pick.sv | 18 +
 rtl/nx1_dpram_arb.sv | 76 +++++++
 tb/tb_nx1_dpram_arb.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/nx1_dpram_arb_pkg.sv
// nx1_dpram_arb_pkg: shared widths, FSM encoding and index helpers for the port-A arbiter
package nx1_dpram_arb_pkg;
  localparam int NREQ = 3;
  localparam int AW = 10;
  localparam int DW = 16;
  typedef enum logic [1:0] {IDLE, ACC, LAT, CAP} state_t;
  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    return oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [1:0] inc3(input logic [1:0] i);
    return i == 2'd2 ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/nx1_dpram_arb_if.sv
// nx1_dpram_arb_if: requester-side bus of the port-A arbiter (three requesters packed side by side)
interface nx1_dpram_arb_if;
  import nx1_dpram_arb_pkg::*;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0] ack;
  logic [DW-1:0] rdata;
  logic [NREQ-1:0] rvalid;
  modport master (output req, we, addr, wdata, input ack, rdata, rvalid);
  modport slave (input req, we, addr, wdata, output ack, rdata, rvalid);
endinterface

// File: rtl/nx1_dpram_arb_pick.sv
// nx1_rr_pick3: combinational 3-way picker, search starts at ptr (or at 0 when fix)
module nx1_rr_pick3
  import nx1_dpram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic       fix,
  output logic [2:0] gnt
);
  logic [1:0] i0, i1, i2;
  // first requester found in order i0, i1, i2 wins
  always_comb begin
    i0 = fix ? 2'd0 : ptr;
    i1 = inc3(i0);
    i2 = inc3(i1);
    gnt = req[i0] ? 3'b001 << i0 : req[i1] ? 3'b001 << i1 : req[i2] ? 3'b001 << i2 : 3'b000;
  end
endmodule

// File: rtl/nx1_dpram_arb.sv
// nx1_dpram_arb: three-requester arbiter/sequencer driving port A of the 1Kx16 dual-port RAM
module nx1_dpram_arb
  import nx1_dpram_arb_pkg::*;
#(
  parameter int RAM_LAT  = 1,
  parameter bit PRIO_FIX = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  nx1_dpram_arb_if.slave bus,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  output logic          ram_cs,
  output logic          ram_we,
  input  logic [DW-1:0] ram_do,
  output logic          busy
);
  state_t state, nxt;
  logic [1:0] cnt, ptr, wi;
  logic [2:0] gnt, win;
  logic wr, grant;
  nx1_rr_pick3 u_pick (.req(bus.req), .ptr(ptr), .fix(PRIO_FIX), .gnt(gnt));
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // next state: writes finish after ACC, reads wait RAM_LAT-1 extra cycles before capture
  always_comb begin
    nxt = state == IDLE ? (|bus.req ? ACC : IDLE) :
          state == ACC  ? (wr ? IDLE : RAM_LAT > 1 ? LAT : CAP) :
          state == LAT  ? (cnt == 2'(RAM_LAT - 2) ? CAP : LAT) : IDLE;
  end
  // outputs: grant only from IDLE, winner index for the request mux
  always_comb begin
    grant = state == IDLE && |bus.req;
    wi = oh2idx(gnt);
    busy = state != IDLE;
  end
  // RAM drive registers, one-cycle ack, round-robin pointer and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ack <= '0;
      ram_cs <= 1'b0;
      ram_we <= 1'b0;
      ram_a <= '0;
      ram_di <= '0;
      win <= '0;
      wr <= 1'b0;
      ptr <= 2'd0;
      cnt <= 2'd0;
    end else begin
      bus.ack <= grant ? gnt : '0;
      ram_cs <= grant;
      ram_we <= grant && bus.we[wi];
      cnt <= state == LAT ? cnt + 2'd1 : 2'd0;
      if (grant) begin
        ram_a <= bus.addr[wi*AW +: AW];
        ram_di <= bus.wdata[wi*DW +: DW];
        win <= gnt;
        wr <= bus.we[wi];
        ptr <= inc3(wi);
      end
    end
  end
  // read capture and valid pulse back to the winning reader
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rvalid <= '0;
      bus.rdata <= '0;
    end else begin
      bus.rvalid <= state == CAP ? win : '0;
      if (state == CAP) bus.rdata <= ram_do;
    end
  end
endmodule

// File: tb/tb_nx1_dpram_arb.sv
// tb_nx1_dpram_arb: directed checks of the port-A arbiter at RAM_LAT 1/3, round-robin and fixed priority
module tb_nx1_dpram_arb;
  import nx1_dpram_arb_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  nx1_dpram_arb_if b1();
  nx1_dpram_arb_if b3();
  nx1_dpram_arb_if bf();
  logic [AW-1:0] a1, a3, af;
  logic [DW-1:0] di1, di3, dif, do1, dof, p0, p1, p2;
  logic cs1, cs3, csf, we1, we3, wef, bz1, bz3, bzf;
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] mem3 [1024];
  logic [DW-1:0] memf [1024];
  nx1_dpram_arb #(.RAM_LAT(1), .PRIO_FIX(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1), .ram_a(a1),
    .ram_di(di1), .ram_cs(cs1), .ram_we(we1), .ram_do(do1), .busy(bz1));
  nx1_dpram_arb #(.RAM_LAT(3), .PRIO_FIX(1'b0)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3), .ram_a(a3),
    .ram_di(di3), .ram_cs(cs3), .ram_we(we3), .ram_do(p2), .busy(bz3));
  nx1_dpram_arb #(.RAM_LAT(1), .PRIO_FIX(1'b1)) uf (.clk(clk), .rst_n(rst_n), .bus(bf), .ram_a(af),
    .ram_di(dif), .ram_cs(csf), .ram_we(wef), .ram_do(dof), .busy(bzf));
  always @(posedge clk) begin
    if (cs1) begin
      if (we1) mem1[a1] <= di1;
      do1 <= mem1[a1];
    end
  end
  always @(posedge clk) begin
    if (cs3) begin
      if (we3) mem3[a3] <= di3;
      p0 <= mem3[a3];
    end
    p1 <= p0;
    p2 <= p1;
  end
  always @(posedge clk) begin
    if (csf) begin
      if (wef) memf[af] <= dif;
      dof <= memf[af];
    end
  end
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] last_rd = 16'h0000;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr1(input int r, input logic [9:0] a, input logic [15:0] d);
    b1.req[r] = 1'b1;
    b1.we[r] = 1'b1;
    b1.addr[r*AW +: AW] = a;
    b1.wdata[r*DW +: DW] = d;
    tick;
    check("wr_ack", 32'(b1.ack), 32'(1) << r);
    check("wr_cs", 32'(cs1), 32'd1);
    check("wr_we", 32'(we1), 32'd1);
    check("wr_a", 32'(a1), 32'(a));
    check("wr_di", 32'(di1), 32'(d));
    b1.req[r] = 1'b0;
    tick;
    check("wr_busy", 32'(bz1), 32'd0);
    check("wr_cs_off", 32'(cs1), 32'd0);
    check("wr_rv", 32'(b1.rvalid), 32'd0);
    check("wr_rdata_hold", 32'(b1.rdata), 32'(last_rd));
  endtask
  task automatic rd1(input int r, input logic [9:0] a, input logic [15:0] d);
    b1.req[r] = 1'b1;
    b1.we[r] = 1'b0;
    b1.addr[r*AW +: AW] = a;
    tick;
    check("rd_ack", 32'(b1.ack), 32'(1) << r);
    check("rd_we", 32'(we1), 32'd0);
    b1.req[r] = 1'b0;
    tick;
    check("rd_rv_early", 32'(b1.rvalid), 32'd0);
    tick;
    check("rd_rv", 32'(b1.rvalid), 32'(1) << r);
    check("rd_data", 32'(b1.rdata), 32'(d));
    last_rd = d;
  endtask
  int order [6] = '{0, 1, 2, 0, 1, 2};
  logic [15:0] dat [3] = '{16'h1111, 16'h2222, 16'h3333};
  int na = 0;
  int nv = 0;
  initial begin
    b1.req = '0; b1.we = '0; b1.addr = '0; b1.wdata = '0;
    b3.req = '0; b3.we = '0; b3.addr = '0; b3.wdata = '0;
    bf.req = '0; bf.we = '0; bf.addr = '0; bf.wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ack", 32'(b1.ack), 32'd0);
    check("rst_rv", 32'(b1.rvalid), 32'd0);
    check("rst_rdata", 32'(b1.rdata), 32'd0);
    check("rst_cs", 32'(cs1), 32'd0);
    check("rst_we", 32'(we1), 32'd0);
    check("rst_a", 32'(a1), 32'd0);
    check("rst_di", 32'(di1), 32'd0);
    check("rst_busy", 32'(bz1), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    wr1(0, 10'h155, 16'hA5C3);
    rd1(1, 10'h155, 16'hA5C3);
    b3.req = 3'b001; b3.we = 3'b001; b3.addr[AW-1:0] = 10'h155; b3.wdata[DW-1:0] = 16'hA5C3;
    tick;
    check("l3_wr_ack", 32'(b3.ack), 32'd1);
    check("l3_wr_cs", 32'(we3 && cs3), 32'd1);
    b3.req = 3'b000;
    tick;
    check("l3_wr_busy", 32'(bz3), 32'd0);
    b3.req = 3'b010; b3.we = 3'b000; b3.addr[2*AW-1:AW] = 10'h155;
    tick;
    check("l3_rd_ack", 32'(b3.ack), 32'd2);
    b3.req = 3'b000;
    repeat (3) tick;
    check("l3_rv_early", 32'(b3.rvalid), 32'd0);
    tick;
    check("l3_rv", 32'(b3.rvalid), 32'd2);
    check("l3_rdata", 32'(b3.rdata), 32'hA5C3);
    check("l3_busy", 32'(bz3), 32'd0);
    wr1(0, 10'h010, 16'h1111);
    wr1(1, 10'h020, 16'h2222);
    wr1(2, 10'h030, 16'h3333);
    b1.we = 3'b000;
    b1.addr = {10'h030, 10'h020, 10'h010};
    b1.req = 3'b111;
    for (int c = 0; c < 40 && nv < 6; c++) begin
      tick;
      if (b1.ack != 3'b000) begin
        if (na < 6) check("rr_ack", 32'(b1.ack), 32'(1) << order[na]);
        else check("rr_extra_ack", 32'(b1.ack), 32'd0);
        na++;
        if (na == 6) b1.req = 3'b000;
      end
      if (b1.rvalid != 3'b000) begin
        check("rr_rv", 32'(b1.rvalid), 32'(1) << order[nv]);
        check("rr_rdata", 32'(b1.rdata), 32'(dat[order[nv]]));
        nv++;
      end
    end
    check("rr_acks", 32'(na), 32'd6);
    check("rr_rvalids", 32'(nv), 32'd6);
    last_rd = 16'h3333;
    b1.addr[AW-1:0] = 10'h155;
    b1.req = 3'b001;
    tick;
    check("wd_ack0", 32'(b1.ack), 32'd1);
    b1.req = 3'b100;
    tick;
    b1.req = 3'b000;
    tick;
    check("wd_rv", 32'(b1.rvalid), 32'd1);
    check("wd_rdata", 32'(b1.rdata), 32'hA5C3);
    last_rd = 16'hA5C3;
    tick;
    check("wd_no_ack", 32'(b1.ack), 32'd0);
    check("wd_busy", 32'(bz1), 32'd0);
    wr1(0, 10'h000, 16'h1234);
    wr1(1, 10'h3FF, 16'hBEEF);
    rd1(0, 10'h3FF, 16'hBEEF);
    rd1(2, 10'h000, 16'h1234);
    bf.we = 3'b111;
    bf.addr = {10'h003, 10'h002, 10'h001};
    bf.req = 3'b110;
    tick;
    check("fx_ack1", 32'(bf.ack), 32'd2);
    bf.req = 3'b101;
    tick;
    check("fx_gap1", 32'(bf.ack), 32'd0);
    tick;
    check("fx_ack0", 32'(bf.ack), 32'd1);
    bf.req = 3'b100;
    tick;
    check("fx_gap2", 32'(bf.ack), 32'd0);
    tick;
    check("fx_ack2", 32'(bf.ack), 32'd4);
    bf.req = 3'b000;
    tick;
    b1.addr[AW-1:0] = 10'h3FF;
    b1.req = 3'b001;
    tick;
    check("t1_pre_ack", 32'(b1.ack), 32'd1);
    check("t1_pre_cs", 32'(cs1), 32'd1);
    b1.req = 3'b000;
    #1 rst_n = 1'b0;
    #1;
    check("t1_ack", 32'(b1.ack), 32'd0);
    check("t1_cs", 32'(cs1), 32'd0);
    check("t1_a", 32'(a1), 32'd0);
    check("t1_rdata", 32'(b1.rdata), 32'd0);
    check("t1_busy", 32'(bz1), 32'd0);
    #4 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      check("t1_no_rv", 32'(b1.rvalid), 32'd0);
    end
    check("t1_busy_after", 32'(bz1), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
